// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: one load/store at a time onto an SRAM-like bus,
// with pipeline stall, byte strobes, store-data replication and misalignment
// detection. Optional macro DMEM_ALIGN_CHECK_EN enables the misalignment checks.
module dmem_access_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        laddrerr,
    output logic        saddrerr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e         state_q,  state_d;
    logic           req_q,    req_d;
    logic           wr_q,     wr_d;
    logic [1:0]     size_q,   size_d;
    logic [AW-1:0]  addr_q,   addr_d;
    logic [SW-1:0]  wstrb_q,  wstrb_d;
    logic [DW-1:0]  wdata_q,  wdata_d;
    logic [DW-1:0]  rdata_q,  rdata_d;
    logic           rvalid_q, rvalid_d;
    logic           cancel_q, cancel_d;

    logic           go_c;
    logic           done_c;
    logic           kill_c;
    logic [SW-1:0]  strb_c;
    logic [DW-1:0]  wrep_c;

`ifdef DMEM_ALIGN_CHECK_EN
    logic misaligned_c;

    // Half needs bit 0 clear, word (and size 3) needs bits [1:0] clear.
    always_comb begin
        misaligned_c = 1'b0;
        case (mem_size)
            2'd0:    misaligned_c = 1'b0;
            2'd1:    misaligned_c = mem_addr[0];
            default: misaligned_c = |mem_addr[1:0];
        endcase
    end

    assign laddrerr = mem_en & ~mem_wr & misaligned_c;
    assign saddrerr = mem_en &  mem_wr & misaligned_c;
`else
    assign laddrerr = 1'b0;
    assign saddrerr = 1'b0;
`endif

    assign go_c = mem_en & ~laddrerr & ~saddrerr & ~flush;

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        strb_c = '0;
        wrep_c = mem_wdata;
        case (mem_size)
            2'd0: begin
                strb_c = SW'(4'b0001 << mem_addr[1:0]);
                wrep_c = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
                strb_c = mem_addr[1] ? SW'(4'b1100) : SW'(4'b0011);
                wrep_c = {2{mem_wdata[15:0]}};
            end
            default: begin
                strb_c = SW'(4'b1111);
                wrep_c = mem_wdata;
            end
        endcase
        if (!mem_wr) begin
            strb_c = '0;
        end
    end

    // Data phase ends either with addr_ok+data_ok together in ADDR, or data_ok in DATA.
    assign done_c = data_data_ok &
                    (((state_q == ADDR) & data_addr_ok) | (state_q == DATA));
    assign kill_c = cancel_q | flush;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        cancel_d = cancel_q;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (go_c) begin
                    state_d = ADDR;
                    req_d   = 1'b1;
                    wr_d    = mem_wr;
                    size_d  = mem_size;
                    addr_d  = mem_addr;
                    wstrb_d = strb_c;
                    wdata_d = wrep_c;
                end
            end
            ADDR: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (data_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A cancelled access still drains the bus but is invisible to the pipeline.
        if (done_c) begin
            if (kill_c) begin
                state_d  = IDLE;
                cancel_d = 1'b0;
            end else begin
                state_d  = HOLD;
                rvalid_d = ~wr_q;
                if (!wr_q) begin
                    rdata_d = data_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cancel_q <= cancel_d;
        end
    end

    // Stall is combinational in IDLE so the launching cycle freezes the pipe too.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            IDLE:       mem_stall = go_c;
            ADDR, DATA: mem_stall = 1'b1;
            default:    mem_stall = 1'b0;
        endcase
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed and randomized transactions checked
// against a transaction-level model of strobes, data, stall length and read return.
module tb_dmem_access_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en, mem_wr, flush;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, mem_rvalid, laddrerr, saddrerr;
    logic [31:0] mem_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] rdata_exp = '0;

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .laddrerr     (laddrerr),
        .saddrerr     (saddrerr),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One pipeline request. ad = ADDR wait cycles before addr_ok, dd = cycles from
    // addr_ok to data_ok (0 = same cycle), fl = flush cycle (-1 none, 0 at launch,
    // k>=1 = k-th bus cycle, kept before the data_ok cycle).
    task automatic run_txn(input logic en, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ad, input int dd, input int fl,
                           input logic [31:0] rd);
        logic        mis, lerr, serr, go, cancel;
        logic [3:0]  strb;
        logic [31:0] rep;
        int          last;

        if (!ALIGN_CHK || sz == 2'd0)  mis = 1'b0;
        else if (sz == 2'd1)           mis = (addr % 2) != 0;
        else                           mis = (addr % 4) != 0;
        lerr = en & ~wr & mis;
        serr = en &  wr & mis;
        go   = en & ~lerr & ~serr & (fl != 0);

        case (sz)
            2'd0: begin
                strb = 4'(1 << (addr % 4));
                rep  = {24'h0, wd[7:0]} * 32'h0101_0101;
            end
            2'd1: begin
                strb = ((addr % 4) >= 2) ? 4'hC : 4'h3;
                rep  = {16'h0, wd[15:0]} * 32'h0001_0001;
            end
            default: begin
                strb = 4'hF;
                rep  = wd;
            end
        endcase
        if (!wr) strb = 4'h0;

        @(negedge clk);
        mem_en = en; mem_wr = wr; mem_size = sz; mem_addr = addr; mem_wdata = wd;
        flush = (fl == 0); data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        chk("t0_stall",    32'(mem_stall),  32'(go));
        chk("t0_laddrerr", 32'(laddrerr),   32'(lerr));
        chk("t0_saddrerr", 32'(saddrerr),   32'(serr));
        chk("t0_req",      32'(data_req),   32'(0));
        chk("t0_rvalid",   32'(mem_rvalid), 32'(0));
        chk("t0_rdata",    mem_rdata,       rdata_exp);

        if (!go) begin
            @(negedge clk);
            mem_en = 1'b0; flush = 1'b0;
            #1;
            chk("nogo_req",   32'(data_req),  32'(0));
            chk("nogo_stall", 32'(mem_stall), 32'(0));
            return;
        end

        last   = ad + 1 + dd;
        cancel = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            flush        = (k == fl);
            data_addr_ok = (k == ad + 1);
            data_data_ok = (k == last);
            data_rdata   = (k == last) ? rd : $urandom;
            #1;
            chk("bus_req",   32'(data_req),   32'(k <= ad + 1));
            chk("bus_stall", 32'(mem_stall),  32'(1));
            chk("bus_addr",  data_addr,       addr);
            chk("bus_wr",    32'(data_wr),    32'(wr));
            chk("bus_size",  32'(data_size),  32'(sz));
            chk("bus_wstrb", 32'(data_wstrb), 32'(strb));
            if (wr) chk("bus_wdata", data_wdata, rep);
            chk("bus_rvalid", 32'(mem_rvalid), 32'(0));
            if (k == fl) cancel = 1'b1;
        end

        if (!cancel) begin
            if (!wr) rdata_exp = rd;
            @(negedge clk);
            flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
            #1;
            chk("hold_stall",  32'(mem_stall),  32'(0));
            chk("hold_rvalid", 32'(mem_rvalid), 32'(!wr));
            chk("hold_rdata",  mem_rdata,       rdata_exp);
            chk("hold_req",    32'(data_req),   32'(0));
        end
    endtask

    initial begin
        resetn = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'd0;
        mem_addr = '0; mem_wdata = '0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",    32'(data_req),   32'(0));
        chk("rst_stall",  32'(mem_stall),  32'(0));
        chk("rst_rvalid", 32'(mem_rvalid), 32'(0));
        chk("rst_rdata",  mem_rdata,       32'(0));
        chk("rst_addr",   data_addr,       32'(0));
        chk("rst_wstrb",  32'(data_wstrb), 32'(0));
        chk("rst_wdata",  data_wdata,      32'(0));
        chk("rst_size",   32'(data_size),  32'(0));
        @(negedge clk);
        resetn = 1'b1;

        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0104, 32'h0,          0, 1, -1, 32'hDEAD_BEEF);
        run_txn(1'b1, 1'b1, 2'd0, 32'h0000_0013, 32'h0000_00A5, 0, 1, -1, 32'h1234_5678);
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,          3, 1, -1, 32'hCAFE_F00D);
        run_txn(1'b1, 1'b0, 2'd1, 32'h0000_0302, 32'h0,          0, 0, -1, 32'h0BAD_CAFE);
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0401, 32'h0,          0, 1, -1, 32'h5555_AAAA);
        run_txn(1'b1, 1'b1, 2'd1, 32'h0000_0503, 32'h0000_BEEF, 0, 1, -1, 32'h0);
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0600, 32'h0,          0, 2,  2, 32'h7777_7777);
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0604, 32'h0,          0, 1, -1, 32'h8888_1111);
        run_txn(1'b1, 1'b1, 2'd2, 32'h0000_0700, 32'h1357_9BDF, 1, 0,  1, 32'h0);
        run_txn(1'b0, 1'b0, 2'd2, 32'h0000_0800, 32'h0,          0, 1, -1, 32'h0);
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0900, 32'h0,          0, 1,  0, 32'h0);

        for (int i = 0; i < 200; i++) begin
            int ad, dd, fl, last;
            ad   = int'($urandom_range(0, 3));
            dd   = int'($urandom_range(0, 2));
            last = ad + 1 + dd;
            fl   = -1;
            if ($urandom_range(0, 9) == 0) fl = 0;
            else if (last > 1 && $urandom_range(0, 3) == 0) fl = int'($urandom_range(1, last - 1));
            run_txn(($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
                    $urandom, $urandom, ad, dd, fl, $urandom);
        end

        @(negedge clk);
        mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_0040;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_pre_req", 32'(data_req), 32'(1));
        #2;
        resetn = 1'b0;
        #1;
        rdata_exp = '0;
        chk("abort_req",   32'(data_req), 32'(0));
        chk("abort_addr",  data_addr,     32'(0));
        chk("abort_rdata", mem_rdata,     rdata_exp);
        @(negedge clk);
        mem_en = 1'b0;
        resetn = 1'b1;
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0A00, 32'h0, 0, 1, -1, 32'h2468_ACE0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
